// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: keeps travelling in one direction while requests lie ahead, then reverses.
// Requests are accepted every cycle with no backpressure; decisions take effect on the strobe edge.
module elevator_scan_ctrl #(
  parameter int FLOORS        = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t      state;
  logic [7:0]  trav_cnt;
  logic [7:0]  door_cnt;
  logic        last_up;

  logic               req_ok;
  logic               req_here;
  logic [FLOORS-1:0]  req_mask;
  logic [FLOORS-1:0]  pend_in;
  logic [FLOOR_W-1:0] arr_floor;
  logic               here_hit;
  logic               any_up;
  logic               any_dn;
  logic               arr_hit;
  logic               arr_more;

  function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    any_above = 1'b0;
    for (int k = 0; k < FLOORS; k++)
      if (k > int'(f) && p[k]) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    any_below = 1'b0;
    for (int k = 0; k < FLOORS; k++)
      if (k < int'(f) && p[k]) any_below = 1'b1;
  endfunction

  function automatic logic [FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    floor_bit = '0;
    for (int k = 0; k < FLOORS; k++)
      if (k == int'(f)) floor_bit[k] = 1'b1;
  endfunction

  always_comb begin
    req_ok   = req_valid && (int'(req_floor) < FLOORS);
    req_here = req_ok && (req_floor == current_floor);
    req_mask = '0;
    // A car already parked or open at the requested floor serves it without latching a bit.
    if (req_ok && !(req_here && (state == IDLE || state == DOOR_OPEN)))
      req_mask = floor_bit(req_floor);
    pend_in   = pending | req_mask;
    arr_floor = (state == MOVE_UP) ? current_floor + 1'b1 : current_floor - 1'b1;
    here_hit  = |(pend_in & floor_bit(current_floor));
    any_up    = any_above(pend_in, current_floor);
    any_dn    = any_below(pend_in, current_floor);
    arr_hit   = |(pend_in & floor_bit(arr_floor));
    arr_more  = (state == MOVE_UP) ? any_above(pend_in, arr_floor)
                                   : any_below(pend_in, arr_floor);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      current_floor <= '0;
      pending       <= '0;
      trav_cnt      <= '0;
      door_cnt      <= '0;
      last_up       <= 1'b1;
    end else begin
      pending <= pend_in;
      case (state)
        IDLE: begin
          if (req_here) begin
            state    <= DOOR_OPEN;
            door_cnt <= '0;
          end else if (here_hit) begin
            state    <= DOOR_OPEN;
            door_cnt <= '0;
            pending  <= pend_in & ~floor_bit(current_floor);
          end else if (any_up && any_dn) begin
            state    <= last_up ? MOVE_UP : MOVE_DOWN;
            trav_cnt <= '0;
          end else if (any_up) begin
            state    <= MOVE_UP;
            last_up  <= 1'b1;
            trav_cnt <= '0;
          end else if (any_dn) begin
            state    <= MOVE_DOWN;
            last_up  <= 1'b0;
            trav_cnt <= '0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (trav_cnt == 8'(TRAVEL_CYCLES - 1)) begin
            trav_cnt      <= '0;
            current_floor <= arr_floor;
            if (arr_hit) begin
              state    <= DOOR_OPEN;
              door_cnt <= '0;
              pending  <= pend_in & ~floor_bit(arr_floor);
            end else if (!arr_more) begin
              state <= IDLE;
            end
          end else begin
            trav_cnt <= trav_cnt + 1'b1;
          end
        end
        DOOR_OPEN: begin
          if (door_hold || req_here) begin
            door_cnt <= '0;
          end else if (door_cnt == 8'(DOOR_CYCLES - 1)) begin
            state    <= IDLE;
            door_cnt <= '0;
          end else begin
            door_cnt <= door_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign moving_up   = (state == MOVE_UP);
  assign moving_down = (state == MOVE_DOWN);
  assign door_open   = (state == DOOR_OPEN);
  assign busy        = (state != IDLE) || (|pending);

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter FLOORS, default 4: number of floors served, legal range 2..16.
REQ-002 Parameter FLOOR_W, default 2: floor index width; SHALL equal ceil(log2(FLOORS)).
REQ-003 Parameter TRAVEL_CYCLES, default 4: clock cycles per one-floor move, legal range 1..255.
REQ-004 Parameter DOOR_CYCLES, default 3: clock cycles the door stays open, legal range 1..255.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  one-cycle strobe qualifying req_floor.
REQ-008 req_floor  input  FLOOR_W  requested floor index.
REQ-009 door_hold  input  1  level; while high in DOOR_OPEN the door timer is held at its start value.
REQ-010 current_floor  output  FLOOR_W  floor the car is at (registered).
REQ-011 moving_up  output  1  high only in state MOVE_UP.
REQ-012 moving_down  output  1  high only in state MOVE_DOWN.
REQ-013 door_open  output  1  high only in state DOOR_OPEN.
REQ-014 pending  output  FLOORS  registered request bitmap, bit k = floor k outstanding.
REQ-015 busy  output  1  high when state is not IDLE or pending is non-zero.

Function
REQ-016 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; one-hot or encoded is an implementation choice, outputs SHALL be decoded from registered state.
REQ-017 req_valid with req_floor < FLOORS SHALL set pending[req_floor] at the next edge; req_floor >= FLOORS SHALL be ignored.
REQ-018 Exception: request for current_floor while in IDLE or DOOR_OPEN SHALL NOT set pending; in IDLE it enters DOOR_OPEN next cycle, in DOOR_OPEN it restarts the door timer.
REQ-019 A last-direction register (reset = UP) SHALL record the direction of the most recent move.
REQ-020 IDLE: if pending[current_floor] -> DOOR_OPEN, clearing that bit; else if requests above and below both exist -> move in last direction; else if any above -> MOVE_UP; else if any below -> MOVE_DOWN; else stay IDLE.
REQ-021 MOVE_UP/MOVE_DOWN: travel counter counts 0..TRAVEL_CYCLES-1; on the edge where it reaches TRAVEL_CYCLES-1, current_floor SHALL change by +1/-1 and the counter reset to 0.
REQ-022 On that arrival edge: if pending[new floor] (including a request strobed on the same edge) -> DOOR_OPEN and clear bit; else if requests remain further in the travel direction -> stay in move state; else -> IDLE.
REQ-023 current_floor SHALL never wrap: MOVE_UP is never entered at FLOORS-1, MOVE_DOWN never at 0.
REQ-024 DOOR_OPEN: door counter counts 0..DOOR_CYCLES-1, held at 0 while door_hold is high; after the final count -> IDLE; door_open is thus high for exactly DOOR_CYCLES cycles absent hold/restart.
REQ-025 A request for a floor being passed mid-travel (counter non-zero) SHALL be serviced on arrival at that floor per REQ-022.
REQ-026 Request strobe and bit-clear for the same floor on the same edge: clear wins only per REQ-018/REQ-022 (door opens at that floor); no second service.

Reset
REQ-027 rst low SHALL immediately force state IDLE, current_floor 0, pending 0, both counters 0, last-direction UP; all status outputs 0.
REQ-028 rst asserted mid-travel or with door open SHALL abandon the operation; no pending requests survive reset.
REQ-029 First state change after rst deasserts SHALL occur no earlier than the first rising clk edge with rst high.

Verification (defaults FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-030 Reset, then req floor 3 -> moving_up next cycle; current_floor 1,2,3 at 4-cycle intervals; door_open 3 cycles at floor 3; then IDLE, busy 0.
REQ-031 At floor 0 moving up to 3, req floor 1 during first segment -> stop at 1 with door open 3 cycles, then continue to 3.
REQ-032 At floor 2 IDLE after moving up, pending {0,3} -> serves 3 first (last direction UP), then 0.
REQ-033 IDLE at floor 1, req floor 1 -> no pending bit, door_open next cycle; door_hold high 5 cycles -> door_open lasts 5+3 cycles.
REQ-034 req_floor 5 with FLOORS=5 override... replaced: req_floor value 3 with FLOORS=3 -> ignored, pending unchanged, state IDLE.
REQ-035 rst low while moving down between floors -> outputs 0, current_floor 0, pending 0 asynchronously, before the next clk edge.
